// File: rtl/snn_image_loader.sv
// Serial-byte to 1-bit input-RAM loader for snn_core: unpacks an image, starts the core, returns the digit.
// Optional: define ASCII_DIGIT_EN to send the result as an ASCII character instead of a raw nibble.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_LOAD  | idle, waiting for the next image byte
//   S_WRITE | writing the 8 pixels of the latched byte, LSB first
//   S_START | one-cycle core_start pulse after the final pixel write
//   S_WAIT  | waiting for snn_core to report done
//   S_SEND  | waiting for the UART transmitter, then pulsing tx_start

module snn_image_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [3:0]            core_digit,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_WRITE,
        S_START,
        S_WAIT,
        S_SEND
    } state_t;

    // Base address of the final byte; reaching it at bit 7 completes the image.
    localparam logic [ADDR_WIDTH-1:0] LAST_BASE = ADDR_WIDTH'(NUM_PIXELS - 8);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;

    function automatic logic [7:0] encode_digit(input logic [3:0] digit);
`ifdef ASCII_DIGIT_EN
        return 8'h30 + {4'b0000, digit};
`else
        return {4'b0000, digit};
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            pix_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= 1'b0;
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;

            // Only LOAD can take a byte; anything else is lost and flagged.
            if (rx_rdy && state != S_LOAD) begin
                overrun <= 1'b1;
            end

            case (state)
                S_LOAD: begin
                    if (rx_rdy) begin
                        shift    <= rx_data;
                        ram_we   <= 1'b1;
                        ram_addr <= pix_cnt;
                        ram_data <= rx_data[0];
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (bit_cnt == 3'd7) begin
                        ram_we  <= 1'b0;
                        pix_cnt <= pix_cnt + ADDR_WIDTH'(8);
                        if (pix_cnt == LAST_BASE) begin
                            core_start <= 1'b1;
                            state      <= S_START;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_LOAD;
                        end
                    end else begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        ram_addr <= ram_addr + ADDR_WIDTH'(1);
                        ram_data <= shift[1];
                        shift    <= {1'b0, shift[7:1]};
                    end
                end

                S_START: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (core_done) begin
                        tx_data <= encode_digit(core_digit);
                        state   <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        busy     <= 1'b0;
                        pix_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= S_LOAD;
                    end
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: stimulus pushes expected RAM writes, starts and tx bytes;
// a forked negedge monitor pops and compares whenever the DUT presents them.

module tb_snn_image_loader;

    localparam int NUM_PIXELS = 784;
    localparam int ADDR_WIDTH = 10;
    localparam int NUM_BYTES  = NUM_PIXELS / 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  rx_rdy = 1'b0;
    logic [7:0]            rx_data = '0;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_data;
    logic                  core_start;
    logic                  core_done = 1'b0;
    logic [3:0]            core_digit = '0;
    logic                  tx_busy = 1'b0;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  busy;
    logic                  overrun;

    snn_image_loader #(.NUM_PIXELS(NUM_PIXELS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit data;
    } wr_t;

    wr_t         wq[$];
    logic [7:0]  txq[$];
    int          exp_starts = 0;
    int          starts_seen = 0;
    int          tx_seen = 0;
    int          model_pix = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] digit_byte(input int d);
`ifdef ASCII_DIGIT_EN
        return 8'(48 + d);
`else
        return 8'(d);
`endif
    endfunction

    task automatic monitor();
        bit prev_we = 0;
        int prev_addr = 0;
        bit prev_tx_busy = 0;
        wr_t e;
        logic [7:0] et;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write_addr", int'(ram_addr), -1);
                end else begin
                    e = wq.pop_front();
                    check("write_addr", int'(ram_addr), e.addr);
                    check("write_data", int'(ram_data), int'(e.data));
                end
                check("busy_during_write", int'(busy), 1);
            end
            if (core_start) begin
                starts_seen++;
                check("core_start_expected", int'(exp_starts > 0), 1);
                if (exp_starts > 0) exp_starts--;
                check("core_start_after_last_write",
                      int'(prev_we && prev_addr == NUM_PIXELS - 1), 1);
            end
            if (tx_start) begin
                tx_seen++;
                if (txq.size() == 0) begin
                    check("unexpected_tx_data", int'(tx_data), -1);
                end else begin
                    et = txq.pop_front();
                    check("tx_data", int'(tx_data), int'(et));
                end
                check("tx_start_after_busy_low", int'(prev_tx_busy), 0);
            end
            prev_we      = ram_we;
            prev_addr    = int'(ram_addr);
            prev_tx_busy = tx_busy;
        end
    endtask

    // Expected writes of an accepted byte: pixel base+k gets bit k.
    task automatic send_byte(input logic [7:0] b);
        wr_t e;
        @(posedge clk); #1;
        rx_rdy  = 1'b1;
        rx_data = b;
        for (int k = 0; k < 8; k++) begin
            e.addr = model_pix + k;
            e.data = b[k];
            wq.push_back(e);
        end
        model_pix += 8;
        if (model_pix == NUM_PIXELS) exp_starts++;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic drop_pulse();
        rx_rdy  = 1'b1;
        rx_data = 8'($urandom);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic settle(input int extra);
        repeat (8 + extra) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_pix = 0;
        wq.delete();
    endtask

    task automatic wait_start(input int target);
        int n = 0;
        while (starts_seen < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("core_start_seen", starts_seen, target);
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_seen < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("tx_start_seen", tx_seen, target);
    endtask

    initial begin
        int digit;
        fork
            monitor();
        join_none

        // reset and idle outputs
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_data", int'(ram_data), 0);
        check("rst_core_start", int'(core_start), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);

        // image 1: 0xA5 then 0xFF bytes; one dropped byte during WRITE
        send_byte(8'hA5);
        settle(1);
        @(negedge clk);
        check("busy_low_after_byte", int'(busy), 0);
        check("overrun_clean", int'(overrun), 0);
        send_byte(8'hFF);
        drop_pulse();
        settle(1);
        @(negedge clk);
        check("overrun_write_drop", int'(overrun), 1);
        for (int i = 2; i < NUM_BYTES; i++) begin
            send_byte(8'hFF);
            settle($urandom_range(0, 3));
        end
        wait_start(1);
        check("busy_in_wait", int'(busy), 1);
        core_digit = 4'd7;
        core_done  = 1'b1;
        txq.push_back(digit_byte(7));
        wait_tx(1);
        core_done = 1'b0;
        repeat (2) @(posedge clk);
        check("busy_idle_after_tx", int'(busy), 0);
        check("starts_image1", starts_seen, 1);

        // image 2: random pixels, drop in WAIT, transmitter busy for 20 cycles
        do_reset();
        @(negedge clk);
        check("overrun_cleared", int'(overrun), 0);
        for (int i = 0; i < NUM_BYTES; i++) begin
            send_byte(8'($urandom));
            settle($urandom_range(0, 2));
        end
        wait_start(2);
        #1 drop_pulse();
        @(negedge clk);
        check("overrun_wait_drop", int'(overrun), 1);
        digit      = int'($urandom_range(0, 9));
        tx_busy    = 1'b1;
        core_digit = 4'(digit);
        core_done  = 1'b1;
        txq.push_back(digit_byte(digit));
        repeat (20) @(posedge clk);
        check("tx_held_off", tx_seen, 1);
        #1 tx_busy = 1'b0;
        wait_tx(2);
        core_done = 1'b0;
        settle(2);

        // image 3: abandoned after 40 bytes, then a fresh byte lands at address 0
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom));
            settle($urandom_range(0, 2));
        end
        check("writes_drained", wq.size(), 0);
        do_reset();
        send_byte(8'h01);
        settle(2);
        @(negedge clk);
        check("overrun_after_reset", int'(overrun), 0);
        check("final_writes_drained", wq.size(), 0);
        check("final_tx_drained", txq.size(), 0);
        check("final_starts", starts_seen, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
